// File: rtl/dmem_resp.sv
// Data-memory responder for the swt16 pipeline: word array, 1-cycle registered
// load response, sticky misaligned flag and saturating access counters.
module dmem_resp #(
  parameter int unsigned DMEM_ADDR_WIDTH = 12,
  parameter int unsigned DMEM_WORD_WIDTH = 16,
  parameter int unsigned DMEM_DEPTH      = 2048,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_act_load_dmem,
  input  logic                       in_act_store_dmem,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_rd_addr,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_wr_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_wr_word,
  output logic [DMEM_WORD_WIDTH-1:0] out_rd_word,
  output logic                       out_rd_valid,
  output logic                       out_misaligned,
  output logic [CNT_WIDTH-1:0]       out_load_cnt,
  output logic [CNT_WIDTH-1:0]       out_store_cnt
);

  localparam int unsigned IDX_W = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  logic [DMEM_WORD_WIDTH-1:0] mem_q [DMEM_DEPTH];

  logic [IDX_W-1:0]           rd_idx;
  logic [IDX_W-1:0]           wr_idx;
  logic                       ld_mis;
  logic                       st_mis;
  logic                       ld_ok;
  logic                       st_ok;
  logic                       wr_en;

  logic [DMEM_WORD_WIDTH-1:0] rd_word_d,    rd_word_q;
  logic                       rd_valid_d,   rd_valid_q;
  logic                       misaligned_d, misaligned_q;
  logic [CNT_WIDTH-1:0]       load_cnt_d,   load_cnt_q;
  logic [CNT_WIDTH-1:0]       store_cnt_d,  store_cnt_q;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Word index drops the byte bit and truncates to the array depth.
  assign rd_idx = IDX_W'(in_dmem_rd_addr >> 1);
  assign wr_idx = IDX_W'(in_dmem_wr_addr >> 1);
  assign ld_mis = in_dmem_rd_addr[0];
  assign st_mis = in_dmem_wr_addr[0];
  assign ld_ok  = in_act_load_dmem  && !ld_mis;
  assign st_ok  = in_act_store_dmem && !st_mis;

  // Next-state: requests in a reset cycle are dropped entirely.
  always_comb begin
    rd_word_d    = '0;
    rd_valid_d   = 1'b0;
    misaligned_d = misaligned_q;
    load_cnt_d   = load_cnt_q;
    store_cnt_d  = store_cnt_q;
    wr_en        = 1'b0;
    if (reset) begin
      misaligned_d = 1'b0;
      load_cnt_d   = '0;
      store_cnt_d  = '0;
    end else begin
      if (in_act_load_dmem) begin
        rd_valid_d = 1'b1;
      end
      if (ld_ok) begin
        // Write-first when a same-cycle aligned store hits the same word.
        rd_word_d  = (st_ok && (wr_idx == rd_idx)) ? in_dmem_wr_word : mem_q[rd_idx];
        load_cnt_d = sat_inc(load_cnt_q);
      end
      if (st_ok) begin
        wr_en       = 1'b1;
        store_cnt_d = sat_inc(store_cnt_q);
      end
      if ((in_act_load_dmem && ld_mis) || (in_act_store_dmem && st_mis)) begin
        misaligned_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_word_q    <= '0;
      rd_valid_q   <= 1'b0;
      misaligned_q <= 1'b0;
      load_cnt_q   <= '0;
      store_cnt_q  <= '0;
    end else begin
      rd_word_q    <= rd_word_d;
      rd_valid_q   <= rd_valid_d;
      misaligned_q <= misaligned_d;
      load_cnt_q   <= load_cnt_d;
      store_cnt_q  <= store_cnt_d;
    end
  end

  // Array contents are not reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_idx] <= in_dmem_wr_word;
    end
  end

  assign out_rd_word    = rd_word_q;
  assign out_rd_valid   = rd_valid_q;
  assign out_misaligned = misaligned_q;
  assign out_load_cnt   = load_cnt_q;
  assign out_store_cnt  = store_cnt_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed self-checking bench for dmem_resp; a second instance with 4-bit
// counters shares the stimulus to exercise counter saturation.
module tb_dmem_resp;

  logic        clock = 1'b0;
  logic        reset;
  logic        ld, st;
  logic [11:0] rd_addr, wr_addr;
  logic [15:0] wr_word;

  logic [15:0] rd_word;
  logic        rd_valid, misaligned;
  logic [15:0] load_cnt, store_cnt;

  logic [15:0] s_rd_word;
  logic        s_rd_valid, s_misaligned;
  logic [3:0]  s_load_cnt, s_store_cnt;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clock = ~clock;

  dmem_resp dut (
    .clock(clock), .reset(reset),
    .in_act_load_dmem(ld), .in_act_store_dmem(st),
    .in_dmem_rd_addr(rd_addr), .in_dmem_wr_addr(wr_addr), .in_dmem_wr_word(wr_word),
    .out_rd_word(rd_word), .out_rd_valid(rd_valid), .out_misaligned(misaligned),
    .out_load_cnt(load_cnt), .out_store_cnt(store_cnt)
  );

  dmem_resp #(.CNT_WIDTH(4)) dut_small (
    .clock(clock), .reset(reset),
    .in_act_load_dmem(ld), .in_act_store_dmem(st),
    .in_dmem_rd_addr(rd_addr), .in_dmem_wr_addr(wr_addr), .in_dmem_wr_word(wr_word),
    .out_rd_word(s_rd_word), .out_rd_valid(s_rd_valid), .out_misaligned(s_misaligned),
    .out_load_cnt(s_load_cnt), .out_store_cnt(s_store_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one cycle of requests, then sample just after the edge.
  task automatic cyc(input logic l, input logic [11:0] ra, input logic s,
                     input logic [11:0] wa, input logic [15:0] wd);
    ld = l; rd_addr = ra; st = s; wr_addr = wa; wr_word = wd;
    @(posedge clock);
    #1;
    ld = 1'b0; st = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] w,
                         input logic m, input int lc, input int sc);
    check({tag, ".valid"}, 32'(rd_valid), 32'(v));
    check({tag, ".word"},  32'(rd_word),  32'(w));
    check({tag, ".mis"},   32'(misaligned), 32'(m));
    check({tag, ".lcnt"},  32'(load_cnt),  32'(lc));
    check({tag, ".scnt"},  32'(store_cnt), 32'(sc));
  endtask

  initial begin
    reset = 1'b1; ld = 1'b0; st = 1'b0; rd_addr = '0; wr_addr = '0; wr_word = '0;
    cyc(0, 12'h000, 0, 12'h000, 16'h0);
    cyc(0, 12'h000, 0, 12'h000, 16'h0);
    chk_out("reset", 0, 16'h0, 0, 0, 0);
    reset = 1'b0;

    // Store then load next cycle.
    cyc(0, 12'h000, 1, 12'h010, 16'hBEEF);
    chk_out("st_beef", 0, 16'h0, 0, 0, 1);
    cyc(1, 12'h010, 0, 12'h000, 16'h0);
    chk_out("ld_beef", 1, 16'hBEEF, 0, 1, 1);

    // Preload words used later.
    cyc(0, 12'h000, 1, 12'h022, 16'h5555);
    cyc(0, 12'h000, 1, 12'h030, 16'h3030);
    cyc(0, 12'h000, 1, 12'h040, 16'h4040);
    chk_out("preload", 0, 16'h0, 0, 1, 4);

    // Same-cycle load/store: same word, then different words.
    cyc(1, 12'h020, 1, 12'h020, 16'h1234);
    chk_out("wr_first", 1, 16'h1234, 0, 2, 5);
    cyc(1, 12'h022, 1, 12'h020, 16'h9999);
    chk_out("diff_idx", 1, 16'h5555, 0, 3, 6);
    cyc(1, 12'h020, 0, 12'h000, 16'h0);
    chk_out("diff_wr", 1, 16'h9999, 0, 4, 6);

    // Misaligned store and load.
    cyc(0, 12'h000, 1, 12'h031, 16'hAAAA);
    chk_out("mis_st", 0, 16'h0, 1, 4, 6);
    cyc(1, 12'h030, 0, 12'h000, 16'h0);
    chk_out("ld_030", 1, 16'h3030, 1, 5, 6);
    cyc(1, 12'h031, 0, 12'h000, 16'h0);
    chk_out("mis_ld", 1, 16'h0, 1, 5, 6);
    cyc(0, 12'h000, 0, 12'h000, 16'h0);
    chk_out("mis_sticky", 0, 16'h0, 1, 5, 6);

    // Back-to-back loads.
    for (int i = 0; i < 4; i++) cyc(0, 12'h000, 1, 12'(2 * i), 16'(i + 1));
    for (int i = 0; i < 4; i++) begin
      cyc(1, 12'(2 * i), 0, 12'h000, 16'h0);
      chk_out($sformatf("b2b%0d", i), 1, 16'(i + 1), 1, 6 + i, 10);
    end
    cyc(0, 12'h000, 0, 12'h000, 16'h0);
    chk_out("b2b_end", 0, 16'h0, 1, 9, 10);

    // Reset drops a same-cycle store and load.
    reset = 1'b1;
    cyc(1, 12'h040, 1, 12'h040, 16'h7777);
    reset = 1'b0;
    chk_out("rst_drop", 0, 16'h0, 0, 0, 0);
    cyc(1, 12'h040, 0, 12'h000, 16'h0);
    chk_out("rst_keep", 1, 16'h4040, 0, 1, 0);

    // Counter saturation on the 4-bit instance.
    for (int i = 0; i < 20; i++) begin
      cyc(1, 12'h000, 0, 12'h000, 16'h0);
      if (i == 13) check("sat_pre", 32'(s_load_cnt), 32'd15);
    end
    check("sat_hold", 32'(s_load_cnt), 32'd15);
    check("sat_scnt", 32'(s_store_cnt), 32'd0);
    check("wide_cnt", 32'(load_cnt), 32'd21);
    check("sat_word", 32'(s_rd_word), 32'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
